// File: rtl/insn_encoder_if.sv
// insn_encoder_if: field-bundle input, encoded-word output and address-load bus of the RV32I encoder.
interface insn_encoder_if #(parameter int width = 32);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [width-1:0] in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] out_insn;
    logic [width-1:0] out_addr;
    logic             out_err;
    logic             addr_load;
    logic [width-1:0] addr_base;
    logic [7:0]       err_count;
    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready, addr_load, addr_base,
        input  in_ready, out_valid, out_insn, out_addr, out_err, err_count
    );
    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready, addr_load, addr_base,
        output in_ready, out_valid, out_insn, out_addr, out_err, err_count
    );
endinterface

// File: rtl/insn_encoder.sv
// insn_encoder: two-stage RV32I field packer; S1 registers fields and the legality check, S2 packs and holds.
module insn_encoder #(parameter int width = 32) (
    input logic clk,
    input logic rst,
    insn_encoder_if.slave bus
);
    localparam logic [2:0] fmt_r = 3'd0, fmt_i = 3'd1, fmt_s = 3'd2, fmt_b = 3'd3, fmt_u = 3'd4, fmt_j = 3'd5;
    localparam logic [31:0] nop = 32'h00000013;
    logic             s1_valid, s1_err;
    logic [2:0]       s1_fmt, s1_f3;
    logic [6:0]       s1_op, s1_f7;
    logic [4:0]       s1_rd, s1_rs1, s1_rs2;
    logic [width-1:0] s1_imm;
    logic             s2_load, hs, imm_ok, in_err;
    logic [width-1:0] imm, packed_insn;
    always_comb begin
        s2_load = !bus.out_valid || bus.out_ready;
        bus.in_ready = !rst && (!s1_valid || s2_load);
        hs = bus.out_valid && bus.out_ready;
        imm = bus.in_imm;
        // Range checks: the immediate must survive sign-extension from its encodable width.
        imm_ok = bus.in_fmt == fmt_r ? 1'b1 :
                 (bus.in_fmt == fmt_i || bus.in_fmt == fmt_s) ? imm == {{20{imm[11]}}, imm[11:0]} :
                 bus.in_fmt == fmt_b ? imm == {{19{imm[12]}}, imm[12:0]} && !imm[0] :
                 bus.in_fmt == fmt_u ? imm[11:0] == 12'd0 :
                 bus.in_fmt == fmt_j ? imm == {{11{imm[20]}}, imm[20:0]} && !imm[0] : 1'b0;
        in_err = !imm_ok || bus.in_opcode[1:0] != 2'b11;
        packed_insn = s1_err ? nop :
                      s1_fmt == fmt_r ? {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op} :
                      s1_fmt == fmt_i ? {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op} :
                      s1_fmt == fmt_s ? {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op} :
                      s1_fmt == fmt_b ? {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:1], s1_imm[11], s1_op} :
                      s1_fmt == fmt_u ? {s1_imm[31:12], s1_rd, s1_op} :
                      {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_err        <= 1'b0;
            s1_fmt        <= '0;
            s1_op         <= '0;
            s1_rd         <= '0;
            s1_rs1        <= '0;
            s1_rs2        <= '0;
            s1_f3         <= '0;
            s1_f7         <= '0;
            s1_imm        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_insn  <= '0;
            bus.out_err   <= 1'b0;
            bus.out_addr  <= '0;
            bus.err_count <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_err <= in_err;
                    s1_fmt <= bus.in_fmt;
                    s1_op  <= bus.in_opcode;
                    s1_rd  <= bus.in_rd;
                    s1_rs1 <= bus.in_rs1;
                    s1_rs2 <= bus.in_rs2;
                    s1_f3  <= bus.in_funct3;
                    s1_f7  <= bus.in_funct7;
                    s1_imm <= bus.in_imm;
                end
            end
            if (s2_load) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_insn <= packed_insn;
                    bus.out_err  <= s1_err;
                end
            end
            // A load on a handshake edge wins; the departing word already carried the old address.
            if (bus.addr_load)
                bus.out_addr <= {bus.addr_base[width-1:2], 2'b00};
            else if (hs)
                bus.out_addr <= bus.out_addr + width'(4);
            if (hs && bus.out_err && bus.err_count != 8'hff)
                bus.err_count <= bus.err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_insn_encoder.sv
// tb_insn_encoder: directed vectors with hand-computed encodings; a monitor matches every output handshake in order.
module tb_insn_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    insn_encoder_if #(.width(32)) bus();
    insn_encoder #(.width(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        err;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int n_chk = 0;
    int n_fail = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask
    task automatic expect_out(input logic [31:0] insn, input logic err, input logic [31:0] addr);
        q.push_back('{insn: insn, addr: addr, err: err});
    endtask
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("extra_output", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("out_insn", bus.out_insn, e.insn);
                check("out_addr", bus.out_addr, e.addr);
                check("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
            end
        end
    end
    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_fmt    = fmt;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask
    task automatic wait_accept();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
        wait_accept();
    endtask
    task automatic addi(input logic [4:0] rd, input logic [31:0] imm);
        send(3'd1, 7'h13, rd, 5'd0, 5'd0, 3'd0, 7'd0, imm);
    endtask
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end
    initial begin
        bus.in_valid = 1'b0;
        drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.addr_load = 1'b0;
        bus.addr_base = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_insn", bus.out_insn, 32'd0);
        check("rst_out_addr", bus.out_addr, 32'd0);
        check("rst_out_err", {31'd0, bus.out_err}, 32'd0);
        check("rst_err_count", {24'd0, bus.err_count}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        expect_out(32'h00500093, 1'b0, 32'd0);
        addi(5'd1, 32'd5);
        @(negedge clk);
        check("latency_cycle1", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("latency_cycle2", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check("rst2_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst2_out_addr", bus.out_addr, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_out(32'hFE208EE3, 1'b0, 32'd0);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
        expect_out(32'h001000EF, 1'b0, 32'd4);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        expect_out(32'h123452B7, 1'b0, 32'd8);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        expect_out(32'h403100B3, 1'b0, 32'd12);
        send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEADBEEF);
        expect_out(32'h0020A423, 1'b0, 32'd16);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        expect_out(32'h7FF00093, 1'b0, 32'd20);
        addi(5'd1, 32'd2047);
        expect_out(32'h00000013, 1'b1, 32'd24);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        cycles(3);
        check("err_count_1", {24'd0, bus.err_count}, 32'd1);
        expect_out(32'h00000013, 1'b1, 32'd28);
        send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        expect_out(32'h00000013, 1'b1, 32'd32);
        addi(5'd1, 32'd2048);
        expect_out(32'h00000013, 1'b1, 32'd36);
        send(3'd1, 7'h12, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        cycles(4);
        check("err_count_4", {24'd0, bus.err_count}, 32'd4);
        check("drain_basic", q.size(), 32'd0);
        bus.out_ready = 1'b0;
        expect_out(32'h00100113, 1'b0, 32'd40);
        expect_out(32'h00200193, 1'b0, 32'd44);
        expect_out(32'h00300213, 1'b0, 32'd48);
        addi(5'd2, 32'd1);
        addi(5'd3, 32'd2);
        drive(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_out_insn", bus.out_insn, 32'h00100113);
            check("stall_out_addr", bus.out_addr, 32'd40);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_accept();
        cycles(4);
        check("drain_stall", q.size(), 32'd0);
        expect_out(32'h00100113, 1'b0, 32'd52);
        expect_out(32'h00200193, 1'b0, 32'h1000);
        expect_out(32'h00300213, 1'b0, 32'h1004);
        addi(5'd2, 32'd1);
        @(posedge clk);
        #1;
        bus.addr_load = 1'b1;
        bus.addr_base = 32'h1003;
        @(posedge clk);
        #1 bus.addr_load = 1'b0;
        addi(5'd3, 32'd2);
        addi(5'd4, 32'd3);
        cycles(4);
        check("drain_load", q.size(), 32'd0);
        bus.addr_load = 1'b1;
        bus.addr_base = 32'hFFFFFFFC;
        @(posedge clk);
        #1 bus.addr_load = 1'b0;
        @(negedge clk);
        check("load_idle_addr", bus.out_addr, 32'hFFFFFFFC);
        @(posedge clk);
        #1;
        expect_out(32'h00100113, 1'b0, 32'hFFFFFFFC);
        expect_out(32'h00200193, 1'b0, 32'd0);
        addi(5'd2, 32'd1);
        addi(5'd3, 32'd2);
        cycles(4);
        check("wrap_addr", bus.out_addr, 32'd4);
        check("drain_wrap", q.size(), 32'd0);
        bus.out_ready = 1'b0;
        addi(5'd5, 32'd7);
        addi(5'd6, 32'd8);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_out_insn", bus.out_insn, 32'd0);
        check("midrst_out_addr", bus.out_addr, 32'd0);
        check("midrst_out_err", {31'd0, bus.out_err}, 32'd0);
        check("midrst_err_count", {24'd0, bus.err_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no_stale_output", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 260; i++) begin
            expect_out(32'h00000013, 1'b1, 32'(4 * i));
            send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        end
        cycles(4);
        check("err_count_sat", {24'd0, bus.err_count}, 32'd255);
        check("drain_sat", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
